vga_fb_scanout: RTL and testbench

Parametrised VGA scan-out engine: generates display timing, fetches 8-bit pixels from an external synchronous framebuffer RAM, and drives RGB and sync outputs. It generalises the fixed 640x480 board renderer. It adds configurable timing, integer upscaling, a centred image window, latency-compensated sync alignment and four frame-latched display modes. It runs entirely on the pixel clock supplied by the PLL outside this block.

---
 rtl/vga_pkg.sv | 57 +++++
 rtl/vga_timing.sv | 49 ++++
 rtl/vga_fb_scanout.sv | 198 +++++++++++++++++++
 tb/tb_vga_fb_scanout.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA framebuffer scan-out engine.
package vga_pkg;

    localparam int CNT_W = 12;

    localparam int VGA_HACTIVE = 640;
    localparam int VGA_HFP     = 16;
    localparam int VGA_HSYNC   = 96;
    localparam int VGA_HBP     = 48;
    localparam int VGA_VACTIVE = 480;
    localparam int VGA_VFP     = 10;
    localparam int VGA_VSYNC   = 2;
    localparam int VGA_VBP     = 33;

    typedef enum logic [1:0] {
        MODE_GRAY  = 2'd0,
        MODE_INV   = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_FALSE = 2'd3
    } mode_t;

    localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB_BLACK   = 24'h000000;

    // Per-pixel control bits carried alongside the memory read.
    typedef struct packed {
        logic       act;
        logic       win;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [2:0] bar;
    } pix_ctl_t;

    localparam pix_ctl_t CTL_IDLE = '{act: 1'b0, win: 1'b0, hs: 1'b1, vs: 1'b1,
                                      fs: 1'b0, bar: 3'd0};

    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with active-area and sync decode.
module vga_timing
    import vga_pkg::*;
#(
    parameter int HACTIVE = VGA_HACTIVE,
    parameter int HFP     = VGA_HFP,
    parameter int HSYNC   = VGA_HSYNC,
    parameter int HBP     = VGA_HBP,
    parameter int VACTIVE = VGA_VACTIVE,
    parameter int VFP     = VGA_VFP,
    parameter int VSYNC   = VGA_VSYNC,
    parameter int VBP     = VGA_VBP
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             hsync,
    output logic             vsync
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HACTIVE + HFP + HSYNC + HBP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VACTIVE + VFP + VSYNC + VBP - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(HACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(VACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(HACTIVE + HFP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(HACTIVE + HFP + HSYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(VACTIVE + VFP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(VACTIVE + VFP + VSYNC);

    // Raster scan: h wraps every line, v advances on h wrap and wraps per frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hsync  = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    assign vsync  = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));

endmodule

// File: rtl/vga_fb_scanout.sv
// VGA scan-out: window addressing, latency-matched control delay line, colour modes.
module vga_fb_scanout
    import vga_pkg::*;
#(
    parameter int          HACTIVE    = VGA_HACTIVE,
    parameter int          HFP        = VGA_HFP,
    parameter int          HSYNC      = VGA_HSYNC,
    parameter int          HBP        = VGA_HBP,
    parameter int          VACTIVE    = VGA_VACTIVE,
    parameter int          VFP        = VGA_VFP,
    parameter int          VSYNC      = VGA_VSYNC,
    parameter int          VBP        = VGA_VBP,
    parameter int          IMG_W      = 256,
    parameter int          IMG_H      = 256,
    parameter int          SCALE_LOG2 = 0,
    parameter int          X0         = 192,
    parameter int          Y0         = 112,
    parameter int          ADDR_W     = 18,
    parameter int          MEM_LAT    = 1,
    parameter logic [23:0] BG         = 24'h000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [7:0]        q,
    output logic [ADDR_W-1:0] rdaddress,
    output logic              hsync,
    output logic              vsync,
    output logic              sync_b,
    output logic              blank_b,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              frame_start
);

    localparam int               BAR_W   = HACTIVE / 8;
    localparam logic [CNT_W-1:0] WX0     = CNT_W'(X0);
    localparam logic [CNT_W-1:0] WX1     = CNT_W'(X0 + (IMG_W << SCALE_LOG2));
    localparam logic [CNT_W-1:0] WX_LAST = CNT_W'(X0 + (IMG_W << SCALE_LOG2) - 1);
    localparam logic [CNT_W-1:0] WY0     = CNT_W'(Y0);
    localparam logic [CNT_W-1:0] WY1     = CNT_W'(Y0 + (IMG_H << SCALE_LOG2));
    localparam logic [1:0]       SUB_MAX = 2'((1 << SCALE_LOG2) - 1);

    logic [CNT_W-1:0]  h_cnt, v_cnt;
    logic              active0, hs0, vs0;
    logic              x_in, y_in;
    logic [ADDR_W-1:0] col, row_base;
    logic [1:0]        h_sub, v_sub;
    logic [2:0]        bar0;
    pix_ctl_t          ctl0, tail;
    pix_ctl_t          dl [MEM_LAT+1];
    mode_t             mode_q;
    logic [23:0]       rgb_d;

    vga_timing #(
        .HACTIVE (HACTIVE), .HFP (HFP), .HSYNC (HSYNC), .HBP (HBP),
        .VACTIVE (VACTIVE), .VFP (VFP), .VSYNC (VSYNC), .VBP (VBP)
    ) u_timing (
        .clk    (clk),
        .rst    (reset),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .active (active0),
        .hsync  (hs0),
        .vsync  (vs0)
    );

    assign x_in = (h_cnt >= WX0) && (h_cnt < WX1);
    assign y_in = (v_cnt >= WY0) && (v_cnt < WY1);

    // Colour-bar index from the screen column (constant compares, no divider).
    always_comb begin
        bar0 = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h_cnt >= CNT_W'(i * BAR_W)) bar0 = 3'(i);
        end
    end

    always_comb begin
        ctl0     = CTL_IDLE;
        ctl0.act = active0;
        ctl0.win = active0 && x_in && y_in;
        ctl0.hs  = hs0;
        ctl0.vs  = vs0;
        ctl0.fs  = (h_cnt == '0) && (v_cnt == '0);
        ctl0.bar = bar0;
    end

    // Source column: steps once per 2^S screen pixels, cleared outside the window columns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col   <= '0;
            h_sub <= '0;
        end else if (!x_in) begin
            col   <= '0;
            h_sub <= '0;
        end else if (h_sub == SUB_MAX) begin
            h_sub <= '0;
            col   <= col + 1'b1;
        end else begin
            h_sub <= h_sub + 1'b1;
        end
    end

    // Source row base: adds IMG_W after every 2^S window lines, cleared above/below the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_base <= '0;
            v_sub    <= '0;
        end else if (!y_in) begin
            row_base <= '0;
            v_sub    <= '0;
        end else if (h_cnt == WX_LAST) begin
            if (v_sub == SUB_MAX) begin
                v_sub    <= '0;
                row_base <= row_base + ADDR_W'(IMG_W);
            end else begin
                v_sub <= v_sub + 1'b1;
            end
        end
    end

    // Read address register; holds its last value outside the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdaddress <= '0;
        end else if (ctl0.win) begin
            rdaddress <= row_base + col;
        end
    end

    // Control delay line: stage 1 plus MEM_LAT stages so the tail lines up with q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= MEM_LAT; i++) dl[i] <= CTL_IDLE;
        end else begin
            dl[0] <= ctl0;
            for (int i = 1; i <= MEM_LAT; i++) dl[i] <= dl[i-1];
        end
    end

    // Mode is sampled only at raster origin so a frame never mixes modes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_GRAY;
        end else if (ctl0.fs) begin
            mode_q <= mode_t'(mode);
        end
    end

    assign tail = dl[MEM_LAT];

    // Pixel colour selection for the pixel at the end of the delay line.
    always_comb begin
        rgb_d = 24'h000000;
        if (tail.act) begin
            if (mode_q == MODE_BARS) begin
                rgb_d = bar_rgb(tail.bar);
            end else if (!tail.win) begin
                rgb_d = BG;
            end else begin
                case (mode_q)
                    MODE_GRAY:  rgb_d = {q, q, q};
                    MODE_INV:   rgb_d = {~q, ~q, ~q};
                    MODE_FALSE: rgb_d = {q[7:5], q[7:5], q[7:6],
                                         q[4:2], q[4:2], q[4:3],
                                         {4{q[1:0]}}};
                    default:    rgb_d = 24'h000000;
                endcase
            end
        end
    end

    // Output register: pixel colour and its syncs leave together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank_b     <= 1'b0;
            frame_start <= 1'b0;
            red         <= 8'h00;
            green       <= 8'h00;
            blue        <= 8'h00;
        end else begin
            hsync       <= tail.hs;
            vsync       <= tail.vs;
            blank_b     <= tail.act;
            frame_start <= tail.fs;
            red         <= rgb_d[23:16];
            green       <= rgb_d[15:8];
            blue        <= rgb_d[7:0];
        end
    end

    assign sync_b = 1'b0;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Self-checking bench: two scan-out instances (unscaled/MEM_LAT=1, 2x scaled/MEM_LAT=3)
// on a reduced raster, compared cycle by cycle against an arithmetic screen model.
module tb_vga_fb_scanout;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
    localparam int VA = 48, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam logic [23:0] BG_A = 24'h123456;
    localparam logic [23:0] BG_B = 24'h0A0B0C;
    localparam int LA = 3;
    localparam int LB = 5;

    logic clk = 1'b0;
    logic reset;
    logic [1:0] mode;
    logic [7:0] qa, qb, qb1, qb2;
    logic [9:0] rda;
    logic [8:0] rdb;
    logic hsa, vsa, sba, bla, fsa, hsb, vsb, sbb, blb, fsb;
    logic [7:0] ra, ga, ba, rb, gb, bb;

    int checks = 0;
    int failures = 0;
    int k = 0;
    int exp_addr_a = 0;
    int exp_addr_b = 0;
    int frame_mode [32];

    always #5 clk = ~clk;

    vga_fb_scanout #(
        .HACTIVE(HA), .HFP(HF), .HSYNC(HS), .HBP(HB),
        .VACTIVE(VA), .VFP(VF), .VSYNC(VS), .VBP(VB),
        .IMG_W(32), .IMG_H(32), .SCALE_LOG2(0), .X0(16), .Y0(8),
        .ADDR_W(10), .MEM_LAT(1), .BG(BG_A)
    ) dut_a (
        .clk(clk), .reset(reset), .mode(mode), .q(qa), .rdaddress(rda),
        .hsync(hsa), .vsync(vsa), .sync_b(sba), .blank_b(bla),
        .red(ra), .green(ga), .blue(ba), .frame_start(fsa)
    );

    vga_fb_scanout #(
        .HACTIVE(HA), .HFP(HF), .HSYNC(HS), .HBP(HB),
        .VACTIVE(VA), .VFP(VF), .VSYNC(VS), .VBP(VB),
        .IMG_W(20), .IMG_H(15), .SCALE_LOG2(1), .X0(12), .Y0(9),
        .ADDR_W(9), .MEM_LAT(3), .BG(BG_B)
    ) dut_b (
        .clk(clk), .reset(reset), .mode(mode), .q(qb), .rdaddress(rdb),
        .hsync(hsb), .vsync(vsb), .sync_b(sbb), .blank_b(blb),
        .red(rb), .green(gb), .blue(bb), .frame_start(fsb)
    );

    function automatic logic [7:0] mem_data(int a);
        logic [31:0] t;
        t = a;
        return t[7:0] ^ {t[9:8], t[9:8], t[9:8], t[9:8]};
    endfunction

    // Framebuffer RAM models with read latency 1 and 3.
    always @(posedge clk) begin
        qa  <= mem_data(int'(rda));
        qb1 <= mem_data(int'(rdb));
        qb2 <= qb1;
        qb  <= qb2;
    end

    function automatic logic [23:0] bar_colour(int i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Framebuffer address of screen pixel (h,v), or -1 outside the image window.
    function automatic int win_addr(int h, int v, int iw, int ih, int s, int x0, int y0);
        if (h < x0 || h >= x0 + iw * (1 << s) || v < y0 || v >= y0 + ih * (1 << s)) return -1;
        return ((v - y0) / (1 << s)) * iw + (h - x0) / (1 << s);
    endfunction

    // Expected {hsync, vsync, blank_b, frame_start, rgb} for raster index n.
    function automatic logic [27:0] model(int n, int iw, int ih, int s, int x0, int y0,
                                          logic [23:0] bg, int md);
        int h, v, a;
        logic hs, vs, bl, fs;
        logic [7:0] d;
        logic [23:0] rgb;
        h = n % HT;
        v = (n / HT) % VT;
        a = win_addr(h, v, iw, ih, s, x0, y0);
        d = mem_data(a);
        hs = !(h >= HA + HF && h < HA + HF + HS);
        vs = !(v >= VA + VF && v < VA + VF + VS);
        bl = (h < HA) && (v < VA);
        fs = (h == 0) && (v == 0);
        rgb = 24'h0;
        if (bl) begin
            if (md == 2) rgb = bar_colour(h / (HA / 8));
            else if (a < 0) rgb = bg;
            else if (md == 0) rgb = {d, d, d};
            else if (md == 1) rgb = {~d, ~d, ~d};
            else rgb = {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], d[1:0], d[1:0], d[1:0], d[1:0]};
        end
        return {hs, vs, bl, fs, rgb};
    endfunction

    // Advance one clock; record the mode sampled at raster origin and the expected read address.
    task automatic step();
        int n, a;
        @(posedge clk);
        k++;
        n = k - 1;
        if (n % FT == 0) frame_mode[(n / FT) % 32] = mode;
        a = win_addr(n % HT, (n / HT) % VT, 32, 32, 0, 16, 8);
        if (a >= 0) exp_addr_a = a;
        a = win_addr(n % HT, (n / HT) % VT, 20, 15, 1, 12, 9);
        if (a >= 0) exp_addr_b = a;
        @(negedge clk);
    endtask

    task automatic release_reset();
        reset = 1'b0;
        k = 0;
        exp_addr_a = 0;
        exp_addr_b = 0;
        for (int i = 0; i < 32; i++) frame_mode[i] = 0;
    endtask

    task automatic test_reset();
        logic [28:0] ra_obs, rb_obs;
        reset = 1'b1;
        mode = 2'd0;
        repeat (3) @(negedge clk);
        ra_obs = {hsa, vsa, bla, fsa, ra, ga, ba, sba};
        rb_obs = {hsb, vsb, blb, fsb, rb, gb, bb, sbb};
        checks++;
        if (ra_obs !== {4'b1100, 24'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_out_a got=%h exp=%h", ra_obs, {4'b1100, 24'h0, 1'b0});
        end
        checks++;
        if (rb_obs !== {4'b1100, 24'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_out_b got=%h exp=%h", rb_obs, {4'b1100, 24'h0, 1'b0});
        end
        checks++;
        if (rda !== 10'd0 || rdb !== 9'd0) begin
            failures++;
            $display("FAIL reset_addr got_a=%0d got_b=%0d exp=0", rda, rdb);
        end
        release_reset();
    endtask

    // policy 0: fixed mode, 1: random mode changes, 2: switch to bars mid-frame after 1000 cycles.
    task automatic test_scanout(int ncyc, int policy);
        logic [28:0] ev, ov;
        for (int i = 0; i < ncyc; i++) begin
            step();
            ev = {4'b1100, 24'h0, 1'b0};
            if (k >= LA) ev = {model(k - LA, 32, 32, 0, 16, 8, BG_A, frame_mode[((k - LA) / FT) % 32]), 1'b0};
            ov = {hsa, vsa, bla, fsa, ra, ga, ba, sba};
            checks++;
            if (ov !== ev) begin
                failures++;
                $display("FAIL pixel_a k=%0d got=%h exp=%h", k, ov, ev);
            end
            ev = {4'b1100, 24'h0, 1'b0};
            if (k >= LB) ev = {model(k - LB, 20, 15, 1, 12, 9, BG_B, frame_mode[((k - LB) / FT) % 32]), 1'b0};
            ov = {hsb, vsb, blb, fsb, rb, gb, bb, sbb};
            checks++;
            if (ov !== ev) begin
                failures++;
                $display("FAIL pixel_b k=%0d got=%h exp=%h", k, ov, ev);
            end
            checks++;
            if (int'(rda) != exp_addr_a) begin
                failures++;
                $display("FAIL addr_a k=%0d got=%0d exp=%0d", k, rda, exp_addr_a);
            end
            checks++;
            if (int'(rdb) != exp_addr_b) begin
                failures++;
                $display("FAIL addr_b k=%0d got=%0d exp=%0d", k, rdb, exp_addr_b);
            end
            if (policy == 1 && $urandom_range(0, 399) == 0) mode = 2'($urandom_range(0, 3));
            if (policy == 2 && i == 1000) mode = 2'd2;
        end
    endtask

    task automatic test_mid_reset();
        int target, cnt;
        logic [28:0] ra_obs, rb_obs;
        // Land inside both image windows, mid-line, so outputs are non-reset when reset hits.
        target = (20 * HT + 30 + int'($urandom_range(0, 3)) + LB) % FT;
        cnt = ((target - k) % FT + FT) % FT;
        test_scanout(cnt, 0);
        checks++;
        if (bla !== 1'b1 || blb !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_active got_a=%b got_b=%b exp=1", bla, blb);
        end
        #2;
        reset = 1'b1;
        #1;
        ra_obs = {hsa, vsa, bla, fsa, ra, ga, ba, sba};
        rb_obs = {hsb, vsb, blb, fsb, rb, gb, bb, sbb};
        checks++;
        if (ra_obs !== {4'b1100, 24'h0, 1'b0}) begin
            failures++;
            $display("FAIL midreset_out_a got=%h exp=%h", ra_obs, {4'b1100, 24'h0, 1'b0});
        end
        checks++;
        if (rb_obs !== {4'b1100, 24'h0, 1'b0}) begin
            failures++;
            $display("FAIL midreset_out_b got=%h exp=%h", rb_obs, {4'b1100, 24'h0, 1'b0});
        end
        checks++;
        if (rda !== 10'd0 || rdb !== 9'd0) begin
            failures++;
            $display("FAIL midreset_addr got_a=%0d got_b=%0d exp=0", rda, rdb);
        end
        repeat (2) @(negedge clk);
        release_reset();
    endtask

    initial begin
        test_reset();
        test_scanout(FT + 400, 0);
        test_scanout(2 * FT, 2);
        test_scanout(3 * FT, 1);
        test_mid_reset();
        mode = 2'd3;
        test_scanout(FT + 200, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
